// File: rtl/ct_idu_id_split_short_seq_if.sv
// Handshake bundle between the ID-stage short-split classifier, the uop sequencer and IR.
// The slave view belongs to the sequencer; the master view is the decode/IR side driving it.
interface ct_idu_id_split_short_seq_if #(
    parameter int INST_W = 32
);
    logic              id_inst_vld;
    logic [INST_W-1:0] id_inst;
    logic [6:0]        id_split_short_type;
    logic              id_inst_rdy;
    logic              uop_vld;
    logic [INST_W-1:0] uop_inst;
    logic [1:0]        uop_idx;
    logic [2:0]        uop_kind;
    logic              uop_last;
    logic              uop_rdy;
    logic              seq_busy;
    logic [15:0]       split_cnt;

    modport master (
        output id_inst_vld, id_inst, id_split_short_type, uop_rdy,
        input  id_inst_rdy, uop_vld, uop_inst, uop_idx, uop_kind, uop_last, seq_busy, split_cnt
    );

    modport slave (
        input  id_inst_vld, id_inst, id_split_short_type, uop_rdy,
        output id_inst_rdy, uop_vld, uop_inst, uop_idx, uop_kind, uop_last, seq_busy, split_cnt
    );
endinterface

// File: rtl/ct_idu_id_split_short_seq.sv
// Short-split uop sequencer: holds one decoded instruction and streams 1 or SPLIT_UOPS uops to IR.
// Optional split statistics counter enabled by defining CT_IDU_SPLIT_STATS_EN.
module ct_idu_id_split_short_seq #(
    parameter int INST_W     = 32,
    parameter int SPLIT_UOPS = 2
) (
    input logic                           forever_cpuclk,
    input logic                           cpurst,
    input logic                           rtu_idu_flush_fe,
    ct_idu_id_split_short_seq_if.slave    bus
);

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    localparam logic [1:0] SPLIT_LAST = 2'(SPLIT_UOPS - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [INST_W-1:0] r_inst;
    logic [1:0]        r_idx;
    logic [2:0]        r_kind;

    logic [INST_W-1:0] w_nextInst;
    logic [1:0]        w_nextIdx;
    logic [2:0]        w_nextKind;
    logic [2:0]        w_newKind;
    logic [1:0]        w_lastIdx;
    logic              w_isLast;
    logic              w_fire;
    logic              w_rdy;
    logic              w_accept;

    // type0 wins over higher types when several classifier bits are set
    always_comb begin
        w_newKind = 3'd0;
        if (bus.id_split_short_type[0]) begin
            w_newKind = 3'd1;
        end else if (bus.id_split_short_type[1]) begin
            w_newKind = 3'd2;
        end else if (bus.id_split_short_type[2]) begin
            w_newKind = 3'd3;
        end else if (bus.id_split_short_type[3]) begin
            w_newKind = 3'd4;
        end
    end

    always_comb begin
        w_lastIdx   = (r_kind != 3'd0) ? SPLIT_LAST : 2'd0;
        w_isLast    = (r_state == ST_ISSUE) && (r_idx == w_lastIdx);
        w_fire      = (r_state == ST_ISSUE) && bus.uop_rdy;
        w_rdy       = !cpurst && !rtu_idu_flush_fe &&
                      ((r_state == ST_IDLE) || (w_fire && w_isLast));
        w_accept    = bus.id_inst_vld && w_rdy;
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        w_nextKind  = r_kind;
        w_nextInst  = r_inst;

        if (rtu_idu_flush_fe) begin
            w_nextState = ST_IDLE;
            w_nextIdx   = 2'd0;
            w_nextKind  = 3'd0;
        end else if (w_accept) begin
            // also covers the last-uop handoff, so a new parent follows with no bubble
            w_nextState = ST_ISSUE;
            w_nextIdx   = 2'd0;
            w_nextKind  = w_newKind;
            w_nextInst  = bus.id_inst;
        end else if (w_fire) begin
            if (w_isLast) begin
                w_nextState = ST_IDLE;
                w_nextIdx   = 2'd0;
                w_nextKind  = 3'd0;
            end else begin
                w_nextIdx   = r_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_inst <= '0;
            r_idx  <= 2'd0;
            r_kind <= 3'd0;
        end else begin
            r_inst <= w_nextInst;
            r_idx  <= w_nextIdx;
            r_kind <= w_nextKind;
        end
    end

`ifdef CT_IDU_SPLIT_STATS_EN
    logic [15:0] r_splitCnt;

    // saturating; survives flush so it reflects the whole run since reset
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_splitCnt <= 16'h0000;
        end else if (w_accept && (w_newKind != 3'd0) && (r_splitCnt != 16'hFFFF)) begin
            r_splitCnt <= r_splitCnt + 16'd1;
        end
    end

    assign bus.split_cnt = r_splitCnt;
`else
    assign bus.split_cnt = 16'h0000;
`endif

    assign bus.id_inst_rdy = w_rdy;
    assign bus.uop_vld     = (r_state == ST_ISSUE);
    assign bus.uop_inst    = r_inst;
    assign bus.uop_idx     = r_idx;
    assign bus.uop_kind    = r_kind;
    assign bus.uop_last    = w_isLast;
    assign bus.seq_busy    = (r_state == ST_ISSUE);

    // reserved classifier bits must never accompany an accepted instruction
    assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        w_accept |-> (bus.id_split_short_type[6:4] == 3'b000));

endmodule

// File: tb/tb_ct_idu_id_split_short_seq.sv
// Randomized self-checking bench for ct_idu_id_split_short_seq against a uop-queue reference model.
// Honours CT_IDU_SPLIT_STATS_EN for the expected split_cnt.
module tb_ct_idu_id_split_short_seq;

    localparam int INST_W     = 32;
    localparam int SPLIT_UOPS = 2;

    typedef struct {
        logic [INST_W-1:0] inst;
        logic [1:0]        idx;
        logic [2:0]        kind;
        logic              last;
    } uop_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    ct_idu_id_split_short_seq_if #(.INST_W(INST_W)) bus ();

    ct_idu_id_split_short_seq #(
        .INST_W    (INST_W),
        .SPLIT_UOPS(SPLIT_UOPS)
    ) u_dut (
        .forever_cpuclk  (clk),
        .cpurst          (rst),
        .rtu_idu_flush_fe(flush),
        .bus             (bus)
    );

    uop_t        expQ[$];
    int          vectorCount = 0;
    int          missCount   = 0;
    logic [15:0] expCnt      = 16'h0000;
    bit          idleClean   = 1'b1;
    bit          resetClean  = 1'b1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [2:0] refKind(input logic [6:0] t);
        for (int b = 0; b < 4; b++) begin
            if (t[b]) return 3'(b + 1);
        end
        return 3'd0;
    endfunction

    // One clock: check registered outputs, drive inputs, check ready, then advance the model
    task automatic applyStimulus(input logic r, input logic f, input logic v,
                                 input logic [INST_W-1:0] inst, input logic [6:0] t, input logic rdy);
        bit         expRdy;
        logic [2:0] kind;
        int         n;
        uop_t       u;

        @(negedge clk);
        checkOutput("uop_vld", bus.uop_vld, expQ.size() != 0);
        checkOutput("seq_busy", bus.seq_busy, expQ.size() != 0);
        checkOutput("split_cnt", bus.split_cnt, expCnt);
        if (expQ.size() != 0) begin
            checkOutput("uop_inst", bus.uop_inst, expQ[0].inst);
            checkOutput("uop_idx", bus.uop_idx, expQ[0].idx);
            checkOutput("uop_kind", bus.uop_kind, expQ[0].kind);
            checkOutput("uop_last", bus.uop_last, expQ[0].last);
        end else begin
            checkOutput("uop_last_idle", bus.uop_last, 1'b0);
            if (idleClean) begin
                checkOutput("uop_idx_idle", bus.uop_idx, 2'd0);
                checkOutput("uop_kind_idle", bus.uop_kind, 3'd0);
            end
            if (resetClean) begin
                checkOutput("uop_inst_rst", bus.uop_inst, '0);
            end
        end

        rst                     = r;
        flush                   = f;
        bus.id_inst_vld         = v;
        bus.id_inst             = inst;
        bus.id_split_short_type = t;
        bus.uop_rdy             = rdy;
        #1;

        expRdy = !r && !f && ((expQ.size() == 0) || ((expQ.size() == 1) && rdy));
        checkOutput("id_inst_rdy", bus.id_inst_rdy, expRdy);

        if (r) begin
            expQ.delete();
            expCnt     = 16'h0000;
            idleClean  = 1'b1;
            resetClean = 1'b1;
        end else if (f) begin
            expQ.delete();
            idleClean = 1'b1;
        end else begin
            if ((expQ.size() != 0) && rdy) begin
                void'(expQ.pop_front());
            end
            if (v && expRdy) begin
                kind = refKind(t);
                n    = (kind != 3'd0) ? SPLIT_UOPS : 1;
                for (int i = 0; i < n; i++) begin
                    u.inst = inst;
                    u.idx  = 2'(i);
                    u.kind = kind;
                    u.last = (i == n - 1);
                    expQ.push_back(u);
                end
                idleClean  = 1'b0;
                resetClean = 1'b0;
`ifdef CT_IDU_SPLIT_STATS_EN
                if ((kind != 3'd0) && (expCnt != 16'hFFFF)) expCnt = expCnt + 16'd1;
`endif
            end
        end
    endtask

    initial begin
        logic              rr, ff, vv, rd;
        logic [6:0]        tt;
        logic [INST_W-1:0] ii;

        rst                     = 1'b1;
        flush                   = 1'b0;
        bus.id_inst_vld         = 1'b0;
        bus.id_inst             = '0;
        bus.id_split_short_type = 7'h00;
        bus.uop_rdy             = 1'b1;
        repeat (2) @(posedge clk);

        applyStimulus(1, 0, 0, 32'h0, 7'h00, 1);

        // single non-split instruction
        applyStimulus(0, 0, 1, 32'h00000013, 7'h00, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);

        // jalr split type0
        applyStimulus(0, 0, 1, 32'h000080E7, 7'h01, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);

        // multiple type bits: lowest wins
        applyStimulus(0, 0, 1, 32'h12345678, 7'h0C, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);

        // back-to-back handoff on the last uop
        applyStimulus(0, 0, 1, 32'hAAAA0001, 7'h02, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);
        applyStimulus(0, 0, 1, 32'hBBBB0002, 7'h08, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);

        // five-cycle stall on idx0 with a pending offer
        applyStimulus(0, 0, 1, 32'hCCCC0003, 7'h04, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 32'hDDDD0004, 7'h00, 0);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);

        // flush after idx0 consumed while an instruction is offered
        applyStimulus(0, 0, 1, 32'hEEEE0005, 7'h01, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);
        applyStimulus(0, 1, 1, 32'hFFFF0006, 7'h00, 1);
        applyStimulus(0, 0, 1, 32'hFFFF0006, 7'h00, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rr = ($urandom_range(63) == 0);
            ff = ($urandom_range(15) == 0);
            vv = 1'($urandom_range(1));
            rd = ($urandom_range(3) != 0);
            tt = ($urandom_range(1) != 0) ? 7'($urandom_range(15)) : 7'h00;
            ii = $urandom;
            applyStimulus(rr, ff, vv, ii, tt, rd);
        end

        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);
        applyStimulus(0, 0, 0, 32'h0, 7'h00, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/ct_idu_id_split_short_seq.md
Name: ct_idu_id_split_short_seq

Overview:
- Consumer-side sequencer for the ID-stage short-split classification (split_short_type[6:0]).
- Accepts one decoded instruction per handshake and emits its micro-op stream towards IR: 1 uop for non-split instructions, 2 uops for any short-split type.
- Provides the buffering and backpressure between the decode classifier and rename; honours frontend flush.

Parameters:
- INST_W, 32, instruction width carried per uop.
- SPLIT_UOPS, 2, uops emitted for a short-split instruction; legal range 2..4.

Ports:
- forever_cpuclk  input  1  core clock
- cpurst  input  1  reset, synchronous, active-high
- rtu_idu_flush_fe  input  1  frontend flush, synchronous
- id_inst_vld  input  1  instruction offered
- id_inst  input  INST_W  instruction bits
- id_split_short_type  input  7  classifier output; bits[6:4] reserved
- id_inst_rdy  output  1  sequencer can accept this cycle
- uop_vld  output  1  uop valid
- uop_inst  output  INST_W  parent instruction bits
- uop_idx  output  2  uop index within parent (0-based)
- uop_kind  output  3  0=no split, 1..4=split type0..3
- uop_last  output  1  final uop of parent
- uop_rdy  input  1  IR accepts uop
- seq_busy  output  1  instruction held, not fully drained
- split_cnt  output  16  split statistic (see Optional Feature)

Behaviour:
- Reset (cpurst=1 at clock edge): state IDLE; uop_vld=0, uop_idx=0, uop_kind=0, uop_last=0, uop_inst=0, seq_busy=0, split_cnt=0. id_inst_rdy=0 while cpurst=1.
- States: IDLE (nothing held) and ISSUE (instruction held; uop_vld=1).
- Accept = id_inst_vld && id_inst_rdy.
- id_inst_rdy = !cpurst && !rtu_idu_flush_fe && (IDLE || (uop_vld && uop_rdy && uop_last)). This allows back-to-back handoff with no bubble.
- On accept:
  - Latch id_inst.
  - kind = lowest set bit of id_split_short_type[3:0] (type0 has highest priority), encoded as index+1; kind = 0 if none is set.
  - total = (kind != 0) ? SPLIT_UOPS : 1.
  - uop_idx = 0. Next cycle: ISSUE, uop_vld=1.
  - Latency from accept to first uop_vld: exactly 1 cycle.
- Bits[6:4] are ignored for kind and count. A simulation assertion fires if any of them is 1 on accept.
- In ISSUE, uop_vld=1 and outputs are held stable until uop_rdy.
- On uop_vld && uop_rdy:
  - If !uop_last: uop_idx increments.
  - If uop_last and no accept in the same cycle: go to IDLE, uop_vld=0.
  - If uop_last and an accept in the same cycle: load the new instruction, stay in ISSUE, uop_idx=0.
- uop_last = (uop_idx == total-1). The counter never wraps beyond total-1.
- seq_busy = (state == ISSUE).
- Flush (rtu_idu_flush_fe=1): highest priority below reset.
  - Next cycle: IDLE, uop_vld=0, uop_idx=0, uop_kind=0, uop_last=0.
  - The held instruction is discarded even mid-sequence (e.g. after uop 0 was consumed).
  - No accept occurs in the flush cycle; an offered instruction is not consumed.
- Reset mid-sequence behaves the same as flush and additionally clears split_cnt.
- uop_rdy=0 indefinitely stalls the sequencer: no accept, outputs held.

Optional Feature:
- Macro CT_IDU_SPLIT_STATS_EN.
- Defined: split_cnt increments by 1 on each accept with kind != 0. It saturates at 16'hFFFF and is not cleared by flush, only by cpurst.
- Undefined: no counter logic; split_cnt is tied to 16'h0000.

Test Plan:
- Non-split offer id_inst=32'h00000013, type=7'h00, uop_rdy=1 -> one uop cycle later: idx=0, kind=0, last=1; returns to IDLE.
- jalr x1 32'h000080E7, type=7'h01, uop_rdy=1 -> two consecutive uops: (idx0, kind1, last0), (idx1, kind1, last1); split_cnt=1 with macro.
- type=7'h0C (bits 2 and 3 set) -> kind=3; 2 uops emitted.
- Back-to-back: second instruction offered during last uop of the first with uop_rdy=1 -> accepted that cycle; no bubble between the last uop of the first and idx0 of the second.
- uop_rdy=0 for 5 cycles during idx0 of a split -> outputs stable, id_inst_rdy=0; after release, idx1 follows.
- Flush asserted after idx0 consumed, with id_inst_vld=1 -> next cycle uop_vld=0, IDLE; offered instruction not accepted in the flush cycle, accepted the following cycle.
